btb_nway_predictor: RTL and testbench
=====================================

Name: btb_nway_predictor

Overview:
Parametrised N-way set-associative branch target buffer, successor of the fixed 4-way BTB in the fetch stage.
- Adds per-entry 2-bit saturating direction counters and a generalised N-way tree-PLRU.
- Resolves update way and tag match internally, so the execute stage no longer echoes way and index.
- Adds a registered lookup pipeline and a sequential flush engine.

Parameters:
SET_COUNT, 16, number of sets (power of 2, >=2)
N, 4, ways per set (power of 2, 2..16)
INDEX_WIDTH, 4, log2(SET_COUNT)
ADDR_WIDTH, 64, PC and target width
BIA_WIDTH, 58, tag width = ADDR_WIDTH - INDEX_WIDTH - 2
CNT_WIDTH, 2, direction counter width

Ports:
i_clk  in  1  clock
i_arst  in  1  reset; one clock; reset is synchronous and active-high
i_lookup_valid  in  1  fetch lookup request
i_pc  in  ADDR_WIDTH  fetch PC; index = pc[INDEX_WIDTH+1:2], tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2]
o_pred_valid  out  1  lookup result valid, one cycle after request
o_hit  out  1  tag match in a valid way
o_taken  out  1  predict taken = o_hit & counter MSB
o_target_addr  out  ADDR_WIDTH  predicted target (0 when !o_hit)
i_update_valid  in  1  resolved branch from execute
i_update_pc  in  ADDR_WIDTH  PC of the resolved branch
i_update_taken  in  1  actual outcome
i_update_target  in  ADDR_WIDTH  actual target
i_flush  in  1  invalidate all entries (single-cycle pulse)
o_busy  out  1  flush in progress

Behaviour:
- Reset (synchronous, i_clk edge with i_arst=1): all valid bits=0, all PLRU bits=0, FSM=IDLE, flush counter=0. Outputs o_pred_valid, o_hit, o_taken, o_busy = 0 and o_target_addr = 0. Reset overrides flush or update in the same cycle; reset mid-flush aborts the flush to IDLE.
- Tag, target and counter arrays are not reset; only valid bits gate use.

Lookup:
- 1-cycle latency: request in cycle t gives o_pred_valid=1 in cycle t+1 with registered o_hit, o_taken and o_target_addr.
- Without a request, o_pred_valid=0 and the other outputs are 0.
- Lookup reads state before same-cycle update writes; there is no bypass.
- While o_busy=1, lookups return o_pred_valid=1 with o_hit=0.

Update (same cycle as i_update_valid, ignored while o_busy):
- Hit in way w, taken: counter +1 saturating at 2^CNT_WIDTH-1; target rewritten; PLRU touched with w.
- Hit, not taken: counter -1 saturating at 0; target unchanged; PLRU touched with w.
- Miss, taken: allocate into the lowest-index invalid way, else the PLRU victim.
  - Write tag and target; counter = 2^(CNT_WIDTH-1) (weakly taken, 2'b10); valid=1; PLRU touched.
- Miss, not taken: no state change.
- Multiple matching ways cannot occur by construction. If they do, the lowest index wins.

PLRU:
- N-1 bits per set, binary tree. Node bit 0 means the victim lies in the left subtree.
- Touch sets every node on the path to point away from the accessed way.
- Lookups do not touch PLRU.

Flush FSM:
- IDLE: on i_flush go to FLUSH, set counter=0, o_busy=1 from the next cycle.
- FLUSH: each cycle clear valid and PLRU of set[counter] and increment the counter.
  - At counter=SET_COUNT-1, clear that set, return to IDLE, and drop o_busy the following cycle.
  - A flush takes exactly SET_COUNT busy cycles.
- i_flush while busy is ignored.
- i_flush together with i_update_valid: flush wins and the update is dropped.

Test Plan:
1. Reset, then lookup pc=0x1000 -> next cycle o_pred_valid=1, o_hit=0, o_taken=0, o_target_addr=0.
2. Update pc=0x1000, taken, target=0x2000; lookup 0x1000 a cycle later -> o_hit=1, o_taken=1, o_target_addr=0x2000.
   - Then two not-taken updates -> counter 2->1->0, o_taken=0 while o_hit=1.
   - Then three taken updates -> counter saturates at 3.
3. Set 0 with N=4: allocate taken branches with tags A,B,C,D (pc=0x0000,0x0040,0x0080,0x00C0 at default params), which fill ways 0..3.
   - Hit-update A, then allocate E -> the victim is tree-PLRU's choice and A remains a hit.
4. Same-cycle lookup and allocating update of pc=0x3000 -> that lookup misses; the next lookup hits.
5. Populate 3 sets, then pulse i_flush -> o_busy high exactly 16 cycles.
   - Updates during busy are ignored; lookups during and after busy miss.
   - i_flush while busy does not extend busy.
6. Assert i_arst at flush cycle 5 -> next cycle o_busy=0 and all lookups miss; assert reset with a pending update -> no allocation.

Source files
------------

// File: rtl/btb_nway_predictor.sv
// N-way set-associative branch target buffer with 2-bit direction counters,
// tree-PLRU replacement, a registered lookup stage and a sequential flush engine.
module btb_nway_predictor #(
   parameter int unsigned SET_COUNT   = 16,
   parameter int unsigned N           = 4,
   parameter int unsigned INDEX_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned BIA_WIDTH   = 58,
   parameter int unsigned CNT_WIDTH   = 2
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_lookup_valid,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   output logic                  o_pred_valid,
   output logic                  o_hit,
   output logic                  o_taken,
   output logic [ADDR_WIDTH-1:0] o_target_addr,
   input  logic                  i_update_valid,
   input  logic [ADDR_WIDTH-1:0] i_update_pc,
   input  logic                  i_update_taken,
   input  logic [ADDR_WIDTH-1:0] i_update_target,
   input  logic                  i_flush,
   output logic                  o_busy
);

   localparam int unsigned WAY_W = $clog2(N);
   localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0]   CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
   localparam logic [INDEX_WIDTH-1:0] LAST_SET = INDEX_WIDTH'(SET_COUNT - 1);

   typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

   state_e                  state_q, state_d;
   logic [INDEX_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
   logic [N-1:0]            valid_q [SET_COUNT];
   logic [N-1:0]            valid_d [SET_COUNT];
   logic [N-2:0]            plru_q  [SET_COUNT];
   logic [N-2:0]            plru_d  [SET_COUNT];
   logic [BIA_WIDTH-1:0]    tag_q   [SET_COUNT][N];
   logic [BIA_WIDTH-1:0]    tag_d   [SET_COUNT][N];
   logic [ADDR_WIDTH-1:0]   tgt_q   [SET_COUNT][N];
   logic [ADDR_WIDTH-1:0]   tgt_d   [SET_COUNT][N];
   logic [CNT_WIDTH-1:0]    cnt_q   [SET_COUNT][N];
   logic [CNT_WIDTH-1:0]    cnt_d   [SET_COUNT][N];

   logic                    pred_valid_q, pred_valid_d;
   logic                    hit_q, hit_d;
   logic                    taken_q, taken_d;
   logic [ADDR_WIDTH-1:0]   target_q, target_d;

   logic [INDEX_WIDTH-1:0]  lk_idx;
   logic [BIA_WIDTH-1:0]    lk_tag;
   logic                    lk_hit;
   logic [WAY_W-1:0]        lk_way;

   logic [INDEX_WIDTH-1:0]  up_idx;
   logic [BIA_WIDTH-1:0]    up_tag;
   logic                    up_en;
   logic                    up_hit;
   logic [WAY_W-1:0]        up_way;
   logic                    free_found;
   logic [WAY_W-1:0]        free_way;
   logic [WAY_W-1:0]        alloc_way;

   // Low two PC bits are instruction alignment and carry no BTB information.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_pc[1:0], i_update_pc[1:0]};

   // Walk the tree from the root following node bits (0 = left) to the victim leaf.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [N-2:0] bits);
      int unsigned node;
      node = 0;
      for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
         node = 2 * node + 1 + 32'(bits[WAY_W'(node)]);
      end
      return WAY_W'(node - (N - 1));
   endfunction

   // Point every node on the path to 'way' towards the opposite subtree.
   function automatic logic [N-2:0] plru_touch(input logic [N-2:0] bits,
                                               input logic [WAY_W-1:0] way);
      logic [N-2:0] res;
      int unsigned  node;
      logic         dir;
      res  = bits;
      node = 0;
      for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
         dir = 1'(way >> (WAY_W - 1 - lvl));
         res[WAY_W'(node)] = ~dir;
         node = 2 * node + 1 + 32'(dir);
      end
      return res;
   endfunction

   // Lookup tag compare against pre-update state; lowest matching way wins.
   always_comb begin
      lk_idx = i_pc[INDEX_WIDTH+1:2];
      lk_tag = i_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
      lk_hit = 1'b0;
      lk_way = '0;
      for (int unsigned w = 0; w < N; w++) begin
         if (!lk_hit && valid_q[lk_idx][WAY_W'(w)] && (tag_q[lk_idx][WAY_W'(w)] == lk_tag)) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
         end
      end
      pred_valid_d = i_lookup_valid;
      hit_d        = i_lookup_valid && lk_hit && (state_q == ST_IDLE);
      taken_d      = hit_d && cnt_q[lk_idx][lk_way][CNT_WIDTH-1];
      target_d     = hit_d ? tgt_q[lk_idx][lk_way] : '0;
   end

   // Update way resolution: matching way, else lowest invalid way, else PLRU victim.
   always_comb begin
      up_idx     = i_update_pc[INDEX_WIDTH+1:2];
      up_tag     = i_update_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
      up_hit     = 1'b0;
      up_way     = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int unsigned w = 0; w < N; w++) begin
         if (!up_hit && valid_q[up_idx][WAY_W'(w)] && (tag_q[up_idx][WAY_W'(w)] == up_tag)) begin
            up_hit = 1'b1;
            up_way = WAY_W'(w);
         end
         if (!free_found && !valid_q[up_idx][WAY_W'(w)]) begin
            free_found = 1'b1;
            free_way   = WAY_W'(w);
         end
      end
      alloc_way = free_found ? free_way : plru_victim(plru_q[up_idx]);
      up_en     = i_update_valid && (state_q == ST_IDLE) && !i_flush;
   end

   // Next-state: flush FSM plus table writes from resolved branches.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      valid_d     = valid_q;
      plru_d      = plru_q;
      tag_d       = tag_q;
      tgt_d       = tgt_q;
      cnt_d       = cnt_q;

      if (up_en) begin
         if (up_hit) begin
            if (i_update_taken) begin
               if (cnt_q[up_idx][up_way] != CNT_MAX) begin
                  cnt_d[up_idx][up_way] = cnt_q[up_idx][up_way] + CNT_WIDTH'(1);
               end
               tgt_d[up_idx][up_way] = i_update_target;
            end else if (cnt_q[up_idx][up_way] != '0) begin
               cnt_d[up_idx][up_way] = cnt_q[up_idx][up_way] - CNT_WIDTH'(1);
            end
            plru_d[up_idx] = plru_touch(plru_q[up_idx], up_way);
         end else if (i_update_taken) begin
            tag_d[up_idx][alloc_way]   = up_tag;
            tgt_d[up_idx][alloc_way]   = i_update_target;
            cnt_d[up_idx][alloc_way]   = CNT_WEAK;
            valid_d[up_idx][alloc_way] = 1'b1;
            plru_d[up_idx]             = plru_touch(plru_q[up_idx], alloc_way);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (i_flush) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end
         end
         ST_FLUSH: begin
            valid_d[flush_cnt_q] = '0;
            plru_d[flush_cnt_q]  = '0;
            flush_cnt_d          = flush_cnt_q + INDEX_WIDTH'(1);
            if (flush_cnt_q == LAST_SET) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state, valid/PLRU bits and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_q      <= ST_IDLE;
         flush_cnt_q  <= '0;
         valid_q      <= '{default: '0};
         plru_q       <= '{default: '0};
         pred_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         taken_q      <= 1'b0;
         target_q     <= '0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         valid_q      <= valid_d;
         plru_q       <= plru_d;
         pred_valid_q <= pred_valid_d;
         hit_q        <= hit_d;
         taken_q      <= taken_d;
         target_q     <= target_d;
      end
   end

   // Payload arrays are gated by valid bits and need no reset.
   always_ff @(posedge i_clk) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
   end

   assign o_pred_valid  = pred_valid_q;
   assign o_hit         = hit_q;
   assign o_taken       = taken_q;
   assign o_target_addr = target_q;
   assign o_busy        = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_btb_nway_predictor.sv
// Directed bench for btb_nway_predictor with a lookup scoreboard and a busy model.
module tb_btb_nway_predictor;

   logic        i_clk = 1'b0;
   logic        i_arst = 1'b0;
   logic        i_lookup_valid = 1'b0;
   logic [63:0] i_pc = '0;
   logic        o_pred_valid;
   logic        o_hit;
   logic        o_taken;
   logic [63:0] o_target_addr;
   logic        i_update_valid = 1'b0;
   logic [63:0] i_update_pc = '0;
   logic        i_update_taken = 1'b0;
   logic [63:0] i_update_target = '0;
   logic        i_flush = 1'b0;
   logic        o_busy;

   typedef struct {
      logic        hit;
      logic        taken;
      logic [63:0] tgt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   busy_left = 0;
   int   busy_seen = 0;

   btb_nway_predictor dut (
      .i_clk          (i_clk),
      .i_arst         (i_arst),
      .i_lookup_valid (i_lookup_valid),
      .i_pc           (i_pc),
      .o_pred_valid   (o_pred_valid),
      .o_hit          (o_hit),
      .o_taken        (o_taken),
      .o_target_addr  (o_target_addr),
      .i_update_valid (i_update_valid),
      .i_update_pc    (i_update_pc),
      .i_update_taken (i_update_taken),
      .i_update_target(i_update_target),
      .i_flush        (i_flush),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic lookup(input logic [63:0] pc, input logic hit, input logic taken,
                         input logic [63:0] tgt);
      exp_t e;
      e.hit = hit; e.taken = taken; e.tgt = tgt;
      i_lookup_valid = 1'b1;
      i_pc = pc;
      sb.push_back(e);
   endtask

   task automatic update(input logic [63:0] pc, input logic taken, input logic [63:0] tgt);
      i_update_valid  = 1'b1;
      i_update_pc     = pc;
      i_update_taken  = taken;
      i_update_target = tgt;
   endtask

   // One clock: advance the busy model, then check outputs #1 after the edge.
   task automatic tick();
      logic lk;
      exp_t e;
      lk = i_lookup_valid && !i_arst;
      if (i_arst) busy_left = 0;
      else if (busy_left > 0) busy_left--;
      else if (i_flush) busy_left = 16;
      @(posedge i_clk);
      #1;
      chk("pred_valid", 64'(o_pred_valid), 64'(lk));
      if (lk) begin
         if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard underflow observed=empty expected=entry");
         end else begin
            e = sb.pop_front();
            chk("hit", 64'(o_hit), 64'(e.hit));
            chk("taken", 64'(o_taken), 64'(e.taken));
            chk("target", o_target_addr, e.tgt);
         end
      end else begin
         chk("idle_hit", 64'(o_hit), 64'(0));
         chk("idle_taken", 64'(o_taken), 64'(0));
         chk("idle_target", o_target_addr, 64'(0));
      end
      chk("busy", 64'(o_busy), 64'(busy_left > 0));
      if (o_busy === 1'b1) busy_seen++;
      i_lookup_valid = 1'b0;
      i_update_valid = 1'b0;
      i_flush        = 1'b0;
      i_arst         = 1'b0;
   endtask

   initial begin
      // Reset state and first lookup miss
      i_arst = 1'b1; tick();
      lookup(64'h1000, 0, 0, 0); tick();
      tick();

      // Allocation, counter decrement/increment with saturation at both ends
      update(64'h1000, 1, 64'h2000); tick();
      lookup(64'h1000, 1, 1, 64'h2000); tick();
      update(64'h1000, 0, 64'hdead); tick();
      lookup(64'h1000, 1, 0, 64'h2000); tick();
      update(64'h1000, 0, 64'hdead); tick();
      lookup(64'h1000, 1, 0, 64'h2000); tick();
      update(64'h1000, 0, 64'hdead); tick();
      update(64'h1000, 1, 64'h2000); tick();
      lookup(64'h1000, 1, 0, 64'h2000); tick();
      update(64'h1000, 1, 64'h2100); tick();
      lookup(64'h1000, 1, 1, 64'h2100); tick();
      update(64'h1000, 1, 64'h2100); tick();
      update(64'h1000, 1, 64'h2100); tick();
      update(64'h1000, 0, 64'h0); tick();
      lookup(64'h1000, 1, 1, 64'h2100); tick();

      // Fill set 0, touch A, allocate E: tree-PLRU evicts C (way 2)
      i_arst = 1'b1; tick();
      update(64'h0000, 1, 64'hA0); tick();
      update(64'h0040, 1, 64'hB0); tick();
      update(64'h0080, 1, 64'hC0); tick();
      update(64'h00C0, 1, 64'hD0); tick();
      lookup(64'h0000, 1, 1, 64'hA0); tick();
      lookup(64'h0040, 1, 1, 64'hB0); tick();
      lookup(64'h0080, 1, 1, 64'hC0); tick();
      lookup(64'h00C0, 1, 1, 64'hD0); tick();
      update(64'h0000, 1, 64'hA1); tick();
      update(64'h0100, 1, 64'hE0); tick();
      lookup(64'h0000, 1, 1, 64'hA1); tick();
      lookup(64'h0040, 1, 1, 64'hB0); tick();
      lookup(64'h0080, 0, 0, 64'h0); tick();
      lookup(64'h00C0, 1, 1, 64'hD0); tick();
      lookup(64'h0100, 1, 1, 64'hE0); tick();

      // Same-cycle lookup and allocation: no bypass; victim is now B (way 1)
      lookup(64'h3000, 0, 0, 64'h0); update(64'h3000, 1, 64'h3333); tick();
      lookup(64'h3000, 1, 1, 64'h3333); tick();
      lookup(64'h0040, 0, 0, 64'h0); tick();
      lookup(64'h0000, 1, 1, 64'hA1); tick();
      lookup(64'h0100, 1, 1, 64'hE0); tick();

      // Flush: exactly 16 busy cycles, updates and re-flush ignored while busy
      i_arst = 1'b1; tick();
      update(64'h104, 1, 64'h1111); tick();
      update(64'h108, 1, 64'h2222); tick();
      update(64'h10C, 1, 64'h3333); tick();
      lookup(64'h104, 1, 1, 64'h1111); tick();
      lookup(64'h108, 1, 1, 64'h2222); tick();
      lookup(64'h10C, 1, 1, 64'h3333); tick();
      busy_seen = 0;
      i_flush = 1'b1; update(64'h110, 1, 64'h4444); tick();
      for (int k = 0; k < 24; k++) begin
         if (k == 3) i_flush = 1'b1;
         if (busy_left > 0) update(64'h114, 1, 64'h5555);
         lookup(64'h104, 0, 0, 64'h0);
         tick();
      end
      chk("busy_cycles", 64'(busy_seen), 64'd16);
      lookup(64'h104, 0, 0, 64'h0); tick();
      lookup(64'h108, 0, 0, 64'h0); tick();
      lookup(64'h10C, 0, 0, 64'h0); tick();
      lookup(64'h110, 0, 0, 64'h0); tick();
      lookup(64'h114, 0, 0, 64'h0); tick();

      // Reset aborts a flush mid-way and overrides a same-cycle update
      i_arst = 1'b1; tick();
      update(64'h104, 1, 64'h6666); tick();
      update(64'h13C, 1, 64'h6767); tick();
      i_flush = 1'b1; tick();
      tick(); tick(); tick(); tick();
      i_arst = 1'b1; tick();
      lookup(64'h104, 0, 0, 64'h0); tick();
      lookup(64'h13C, 0, 0, 64'h0); tick();
      i_arst = 1'b1; update(64'h200, 1, 64'h7777); tick();
      lookup(64'h200, 0, 0, 64'h0); tick();
      update(64'h13C, 1, 64'h9999); tick();
      lookup(64'h13C, 1, 1, 64'h9999); tick();
      tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
